coin_bcd_display: RTL and testbench

COIN_BCD_DISPLAY -- requirements
Module: coin_bcd_display

---
 rtl/coin_bcd_display.sv | 171 +++++++++++++++++
 tb/tb_coin_bcd_display.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_bcd_display.sv
// coin_bcd_display: serial double-dabble binary-to-BCD converter that drives an
// active-low multi-digit 7-segment display, with dashes on overflow.
module coin_bcd_display #(
   parameter int WIDTH    = 12,
   parameter int DIGITS   = 4,
   parameter int BLANK_LZ = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [WIDTH-1:0]      value,
   output logic                  busy,
   output logic                  done,
   output logic [DIGITS*7-1:0]   seg,
   output logic                  overflow
);

   // ceil(w*log10(2)) decimal digits are needed to hold 2^w-1
   function automatic int calc_nibbles(input int w);
      int n;
      n = (w * 30103 + 99999) / 100000;
      return (n < 1) ? 1 : n;
   endfunction

   localparam int NB = calc_nibbles(WIDTH);
   localparam int ND = (NB > DIGITS) ? NB : DIGITS;
   localparam int DW = NB * 4 + WIDTH;
   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [6:0] SEG_ZERO  = 7'b100_0000;
   localparam logic [6:0] SEG_BLANK = 7'b111_1111;
   localparam logic [6:0] SEG_DASH  = 7'b011_1111;

   function automatic logic [6:0] encode_digit(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b100_0000;
         4'd1:    return 7'b111_1001;
         4'd2:    return 7'b010_0100;
         4'd3:    return 7'b011_0000;
         4'd4:    return 7'b001_1001;
         4'd5:    return 7'b001_0010;
         4'd6:    return 7'b000_0010;
         4'd7:    return 7'b111_1000;
         4'd8:    return 7'b000_0000;
         4'd9:    return 7'b001_0000;
         default: return SEG_DASH;
      endcase
   endfunction

   function automatic logic [DIGITS*7-1:0] reset_pattern();
      logic [DIGITS*7-1:0] p;
      for (int k = 0; k < DIGITS; k++) begin
         p[k*7 +: 7] = (k == 0 || BLANK_LZ == 0) ? SEG_ZERO : SEG_BLANK;
      end
      return p;
   endfunction

   localparam logic [DIGITS*7-1:0] SEG_RESET = reset_pattern();

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      UPDATE  = 2'd2
   } state_t;

   state_t               state_reg;
   logic [DW-1:0]        dd_reg;       // {bcd accumulator, binary shift register}
   logic [CW-1:0]        cnt_reg;
   logic                 busy_reg;
   logic                 done_reg;
   logic                 ovf_reg;
   logic [DIGITS*7-1:0]  seg_reg;

   logic [DW-1:0]        dd_next;
   logic [ND*4-1:0]      bcd_ext;
   logic                 ovf_next;
   logic [DIGITS*7-1:0]  seg_next;

   // Add-3 correction on every nibble before the shift
   assign dd_next[WIDTH-1:0] = dd_reg[WIDTH-1:0];
   generate
      for (genvar gi = 0; gi < NB; gi++) begin : g_adj
         assign dd_next[WIDTH+gi*4 +: 4] = (dd_reg[WIDTH+gi*4 +: 4] >= 4'd5) ?
                                           dd_reg[WIDTH+gi*4 +: 4] + 4'd3 :
                                           dd_reg[WIDTH+gi*4 +: 4];
      end
   endgenerate

   // Widen the accumulator so display logic never indexes past it
   generate
      for (genvar gi = 0; gi < ND; gi++) begin : g_ext
         if (gi < NB) begin : g_real
            assign bcd_ext[gi*4 +: 4] = dd_reg[WIDTH+gi*4 +: 4];
         end else begin : g_pad
            assign bcd_ext[gi*4 +: 4] = 4'd0;
         end
      end
   endgenerate

   generate
      if (ND > DIGITS) begin : g_ovf
         assign ovf_next = |bcd_ext[ND*4-1:DIGITS*4];
      end else begin : g_no_ovf
         assign ovf_next = 1'b0;
      end
   endgenerate

   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_seg
         if (gi == 0 || BLANK_LZ == 0) begin : g_plain
            assign seg_next[gi*7 +: 7] = ovf_next ? SEG_DASH :
                                         encode_digit(bcd_ext[gi*4 +: 4]);
         end else begin : g_blank
            logic upper_zero;
            // This digit and everything above it are zero -> leading zero
            assign upper_zero = (bcd_ext[DIGITS*4-1:gi*4] == '0);
            assign seg_next[gi*7 +: 7] = ovf_next   ? SEG_DASH  :
                                         upper_zero ? SEG_BLANK :
                                         encode_digit(bcd_ext[gi*4 +: 4]);
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         dd_reg    <= '0;
         cnt_reg   <= '0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
         ovf_reg   <= 1'b0;
         seg_reg   <= SEG_RESET;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  dd_reg    <= {{(NB*4){1'b0}}, value};
                  cnt_reg   <= CW'(WIDTH);
                  busy_reg  <= 1'b1;
                  state_reg <= CONVERT;
               end
            end
            CONVERT: begin
               dd_reg  <= dd_next << 1;
               cnt_reg <= cnt_reg - CW'(1);
               if (cnt_reg == CW'(1)) begin
                  state_reg <= UPDATE;
               end
            end
            UPDATE: begin
               seg_reg   <= seg_next;
               ovf_reg   <= ovf_next;
               done_reg  <= 1'b1;
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign busy     = busy_reg;
   assign done     = done_reg;
   assign seg      = seg_reg;
   assign overflow = ovf_reg;

endmodule

// File: tb/tb_coin_bcd_display.sv
// Self-checking bench for coin_bcd_display: a decimal-arithmetic reference model
// checked every cycle on the default instance, plus directed literal checks.
module tb_coin_bcd_display;

   localparam int W = 12;
   localparam logic [6:0] SZ = 7'b100_0000;
   localparam logic [6:0] SB = 7'b111_1111;
   localparam logic [6:0] SD = 7'b011_1111;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        start = 1'b0;
   logic [11:0] value = '0;
   logic        busy, done, overflow;
   logic [27:0] seg;

   logic        start_b = 1'b0;
   logic [11:0] value_b = '0;
   logic        busy_b, done_b, overflow_b;
   logic [27:0] seg_b;

   logic        start_w = 1'b0;
   logic [15:0] value_w = '0;
   logic        busy_w, done_w, overflow_w;
   logic [27:0] seg_w;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   coin_bcd_display #(.WIDTH(12), .DIGITS(4), .BLANK_LZ(0)) dut (
      .clk(clk), .rst(rst), .start(start), .value(value),
      .busy(busy), .done(done), .seg(seg), .overflow(overflow));

   coin_bcd_display #(.WIDTH(12), .DIGITS(4), .BLANK_LZ(1)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .value(value_b),
      .busy(busy_b), .done(done_b), .seg(seg_b), .overflow(overflow_b));

   coin_bcd_display #(.WIDTH(16), .DIGITS(4), .BLANK_LZ(0)) dut_w (
      .clk(clk), .rst(rst), .start(start_w), .value(value_w),
      .busy(busy_w), .done(done_w), .seg(seg_w), .overflow(overflow_w));

   function automatic logic [6:0] enc(input int d);
      case (d)
         0: return 7'b100_0000;
         1: return 7'b111_1001;
         2: return 7'b010_0100;
         3: return 7'b011_0000;
         4: return 7'b001_1001;
         5: return 7'b001_0010;
         6: return 7'b000_0010;
         7: return 7'b111_1000;
         8: return 7'b000_0000;
         9: return 7'b001_0000;
         default: return SD;
      endcase
   endfunction

   // Four-digit display of v computed with plain decimal arithmetic
   function automatic logic [27:0] ref_seg4(input int v, input bit blank);
      logic [27:0] r;
      int p;
      p = 1;
      for (int k = 0; k < 4; k++) begin
         if (v > 9999)                       r[k*7 +: 7] = SD;
         else if (blank && k > 0 && v < p)   r[k*7 +: 7] = SB;
         else                                r[k*7 +: 7] = enc((v / p) % 10);
         p = p * 10;
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input int which, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if ((which == 0 && done) || (which == 1 && done_b) || (which == 2 && done_w)) begin
            ok = 1'b1;
            return;
         end
      end
      checks++;
      errors++;
      $display("FAIL done_timeout: dut %0d got no done, expected done within 40 cycles", which);
   endtask

   // Reference timeline for the default instance: edges counted since reset
   int          cyc     = 0;
   int          acc     = -1;
   int          acc_val = 0;
   bit          m_busy  = 1'b0;
   bit          m_done  = 1'b0;
   bit          m_ovf   = 1'b0;
   logic [27:0] m_seg   = {4{SZ}};

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         cyc = 0; acc = -1; m_busy = 1'b0; m_done = 1'b0; m_ovf = 1'b0;
         m_seg = {4{SZ}};
      end else begin
         cyc++;
         m_done = 1'b0;
         if (acc >= 0 && cyc == acc + W + 1) begin
            m_seg  = ref_seg4(acc_val, 1'b0);
            m_ovf  = (acc_val > 9999);
            m_done = 1'b1;
         end
         if ((acc < 0 || cyc >= acc + W + 2) && start) begin
            acc     = cyc;
            acc_val = int'(value);
         end
         m_busy = (acc >= 0) && (cyc <= acc + W);
      end
   end

   always @(negedge clk) begin
      chk("model_busy", 64'(busy), 64'(m_busy));
      chk("model_done", 64'(done), 64'(m_done));
      chk("model_seg", 64'(seg), 64'(m_seg));
      chk("model_ovf", 64'(overflow), 64'(m_ovf));
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int bc, dc, dl, nd;
      bit ok;

      rst = 1'b1;
      repeat (3) tick();
      chk("reset_seg", 64'(seg), 64'({4{SZ}}));
      chk("reset_seg_blank", 64'(seg_b), 64'({SB, SB, SB, SZ}));
      chk("reset_seg_w", 64'(seg_w), 64'({4{SZ}}));
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_ovf", 64'(overflow_w), 64'd0);
      rst = 1'b0;
      tick();

      // 1500 on defaults: latency, busy length, single done, literal segments
      value = 12'd1500; start = 1'b1;
      tick();
      start = 1'b0;
      bc = busy ? 1 : 0; dc = 0; dl = -1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (busy) bc++;
         if (done) begin dc++; dl = i; end
      end
      chk("1500_busy_cycles", 64'(bc), 64'd13);
      chk("1500_done_count", 64'(dc), 64'd1);
      chk("1500_done_latency", 64'(dl), 64'd13);
      chk("1500_seg", 64'(seg), 64'({7'b111_1001, 7'b001_0010, 7'b100_0000, 7'b100_0000}));
      chk("1500_ovf", 64'(overflow), 64'd0);

      // Leading-zero blanking
      value_b = 12'd0; start_b = 1'b1;
      tick();
      start_b = 1'b0;
      wait_done(1, ok);
      chk("blank_0_seg", 64'(seg_b), 64'({SB, SB, SB, SZ}));
      tick();
      value_b = 12'd700; start_b = 1'b1;
      tick();
      start_b = 1'b0;
      wait_done(1, ok);
      chk("blank_700_seg", 64'(seg_b), 64'({SB, 7'b111_1000, SZ, SZ}));

      // Overflow on a 16-bit instance, then the largest displayable value
      value_w = 16'd12000; start_w = 1'b1;
      tick();
      start_w = 1'b0;
      wait_done(2, ok);
      chk("w12000_ovf", 64'(overflow_w), 64'd1);
      chk("w12000_seg", 64'(seg_w), 64'({4{SD}}));
      tick();
      value_w = 16'd9999; start_w = 1'b1;
      tick();
      start_w = 1'b0;
      wait_done(2, ok);
      chk("w9999_ovf", 64'(overflow_w), 64'd0);
      chk("w9999_seg", 64'(seg_w), 64'({4{7'b001_0000}}));

      // start held high with value changing every cycle
      start = 1'b1;
      value = 12'($urandom_range(0, 4095));
      nd = 0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (done) nd++;
         value = 12'($urandom_range(0, 4095));
      end
      start = 1'b0;
      chk("held_start_dones", 64'(nd), 64'd4);
      wait_done(0, ok);
      tick();

      // Reset in the middle of a conversion
      value = 12'd4095; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      chk("abort_busy_before", 64'(busy), 64'd1);
      rst = 1'b1;
      #1;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_seg", 64'(seg), 64'({4{SZ}}));
      tick();
      rst = 1'b0;
      nd = 0;
      repeat (20) begin
         tick();
         if (done) nd++;
      end
      chk("abort_no_done", 64'(nd), 64'd0);
      value = 12'd300; start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(0, ok);
      chk("after_abort_300", 64'(seg), 64'({SZ, 7'b011_0000, SZ, SZ}));

      // Exhaustive sweep of the default instance
      nd = 0;
      for (int v = 0; v < 4096; v++) begin
         value = 12'(v); start = 1'b1;
         tick();
         start = 1'b0;
         wait_done(0, ok);
         if (ok) begin
            nd++;
            chk("sweep_seg", 64'(seg), 64'(ref_seg4(v, 1'b0)));
         end
      end
      chk("sweep_done_count", 64'(nd), 64'd4096);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
